// File: rtl/sr_cmd_driver.sv
// rtl/sr_cmd_driver.sv - command driver for an SR flop with readback, retry and sticky error
module sr_cmd_driver #(
  parameter int CHECK_DLY = 1,  // idle cycles between the s/r pulse and the q_fb sample (1..15)
  parameter int MAX_RETRY = 2   // re-drives allowed after a mismatch before flagging err (0..7)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       err_clr,
  output logic       q_exp
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  localparam logic [3:0] DLY_INIT  = 4'(CHECK_DLY - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_ERROR
  } state_t;

  state_t     state_q, state_d;
  logic       target_q, target_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] retry_q, retry_d;
  logic       q_exp_d;
  logic       done_d;
  logic       s_d, r_d, err_d;
  logic       accept;

  // Handshake: only an idle, error-free driver takes a new command.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE) && !err;
    busy      = (state_q != ST_IDLE);
    accept    = cmd_valid && cmd_ready;
  end

  // Next-state and next-output decode; pulse outputs are derived from the
  // next state so s/r/done/err all come straight out of flops.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    q_exp_d  = q_exp;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_NOP) begin
            done_d = 1'b1;
          end else begin
            case (cmd_op)
              OP_CLEAR: target_d = 1'b0;
              OP_SET:   target_d = 1'b1;
              default:  target_d = ~q_exp;
            endcase
            retry_d = 3'd0;
            state_d = ST_DRIVE;
          end
        end
      end

      ST_DRIVE: begin
        cnt_d   = DLY_INIT;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_CHECK: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          q_exp_d = target_q;
          state_d = ST_IDLE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 3'd1;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_ERROR;
        end
      end

      ST_ERROR: begin
        if (err_clr) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // s and r are mutually exclusive by construction: both key off DRIVE
    // and split on a single target bit.
    s_d   = (state_d == ST_DRIVE) && target_d;
    r_d   = (state_d == ST_DRIVE) && !target_d;
    err_d = (state_d == ST_ERROR);
  end

  // State and registered outputs; reset drops any in-flight pulse at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= 1'b0;
      cnt_q    <= 4'd0;
      retry_q  <= 3'd0;
      q_exp    <= 1'b0;
      done     <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      q_exp    <= q_exp_d;
      done     <= done_d;
      s        <= s_d;
      r        <= r_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// tb/tb_sr_cmd_driver.sv - scoreboard bench for sr_cmd_driver
module tb_sr_cmd_driver;

  localparam int D  = 1;
  localparam int MR = 2;
  localparam int D3 = 3;

  typedef struct {
    int   cyc;
    logic q;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_valid3;
  logic [1:0] cmd_op, cmd_op3;
  logic       cmd_ready, cmd_ready3;
  logic       s, r, s3, r3;
  logic       q_fb, q_fb3;
  logic       busy, busy3;
  logic       done, done3;
  logic       err, err3;
  logic       err_clr;
  logic       q_exp, q_exp3;

  logic       q_int, q_int3;
  logic       stuck;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic exp_q;
  int   last_acc;
  int   rd = 0;

  // monitor-owned records
  int   s_cnt = 0;
  int   r_cnt = 0;
  int   done_cnt = 0;
  int   s_cyc_arr[256];
  int   done_cyc_arr[256];
  logic done_q_arr[256];
  logic both_seen = 1'b0;

  sr_cmd_driver #(.CHECK_DLY(D), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .s(s), .r(r), .q_fb(q_fb), .busy(busy),
    .done(done), .err(err), .err_clr(err_clr), .q_exp(q_exp)
  );

  sr_cmd_driver #(.CHECK_DLY(D3), .MAX_RETRY(MR)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_op(cmd_op3),
    .cmd_ready(cmd_ready3), .s(s3), .r(r3), .q_fb(q_fb3), .busy(busy3),
    .done(done3), .err(err3), .err_clr(1'b0), .q_exp(q_exp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SR flop models driven by each DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_int  <= 1'b0;
      q_int3 <= 1'b0;
    end else begin
      if (s) q_int <= 1'b1;
      else if (r) q_int <= 1'b0;
      if (s3) q_int3 <= 1'b1;
      else if (r3) q_int3 <= 1'b0;
    end
  end
  assign q_fb  = stuck ? 1'b0 : q_int;
  assign q_fb3 = q_int3;

  always @(negedge clk) begin
    if ((s && r) || (s3 && r3)) both_seen = 1'b1;
    if (s) begin
      if (s_cnt < 256) s_cyc_arr[s_cnt] = cyc;
      s_cnt++;
    end
    if (r) r_cnt++;
    if (done) begin
      if (done_cnt < 256) begin
        done_cyc_arr[done_cnt] = cyc;
        done_q_arr[done_cnt]   = q_exp;
      end
      done_cnt++;
    end
  end

  task automatic send(input logic [1:0] op, input bit expect_done);
    bit   got;
    logic nq;
    exp_t e;
    got = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL accept_timeout op=%0d cmd_ready=%b required 1", op, cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      last_acc  = cyc;
      cmd_valid = 1'b0;
      case (op)
        2'b01:   nq = 1'b0;
        2'b10:   nq = 1'b1;
        2'b11:   nq = ~exp_q;
        default: nq = exp_q;
      endcase
      if (expect_done) begin
        e.cyc = (op == 2'b00) ? last_acc : last_acc + D + 2;
        e.q   = nq;
        sb.push_back(e);
        exp_q = nq;
      end
    end
  endtask

  task automatic drain;
    exp_t e;
    bit   got;
    while (sb.size() > 0) begin
      got = (done_cnt > rd);
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = (done_cnt > rd);
      end
      e = sb.pop_front();
      n_cmp++;
      if (!got) begin
        n_err++;
        $display("FAIL done_timeout got none required done at cyc %0d", e.cyc);
      end else begin
        n_cmp++;
        if (done_cyc_arr[rd] !== e.cyc) begin
          n_err++;
          $display("FAIL done_cycle got %0d required %0d", done_cyc_arr[rd], e.cyc);
        end
        if (done_q_arr[rd] !== e.q) begin
          n_err++;
          $display("FAIL done_q_exp got %b required %b", done_q_arr[rd], e.q);
        end
        rd++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({s, r, done, err, busy, q_exp} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs s,r,done,err,busy,q_exp=%b required 000000",
               {s, r, done, err, busy, q_exp});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || cmd_ready3 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b/%b required 1/1", cmd_ready, cmd_ready3);
    end
  endtask

  task automatic test_set;
    int s0, r0;
    s0 = s_cnt;
    r0 = r_cnt;
    send(2'b10, 1'b1);
    drain();
    n_cmp++;
    if (s_cnt - s0 !== 1 || r_cnt !== r0) begin
      n_err++;
      $display("FAIL set_pulses s=%0d r=%0d required 1 0", s_cnt - s0, r_cnt - r0);
    end
    n_cmp++;
    if (s_cyc_arr[s0] !== last_acc) begin
      n_err++;
      $display("FAIL set_pulse_cycle got %0d required %0d", s_cyc_arr[s0], last_acc);
    end
    n_cmp++;
    if (q_fb !== 1'b1 || q_exp !== 1'b1) begin
      n_err++;
      $display("FAIL set_state q_fb=%b q_exp=%b required 1 1", q_fb, q_exp);
    end
  endtask

  task automatic test_back_to_back;
    int s0, r0, k1;
    s0 = s_cnt;
    r0 = r_cnt;
    send(2'b01, 1'b1);
    k1 = last_acc;
    send(2'b11, 1'b1);
    drain();
    n_cmp++;
    if (last_acc - k1 !== D + 3) begin
      n_err++;
      $display("FAIL b2b_accept_gap got %0d required %0d", last_acc - k1, D + 3);
    end
    n_cmp++;
    if (r_cnt - r0 !== 1 || s_cnt - s0 !== 1) begin
      n_err++;
      $display("FAIL b2b_pulses s=%0d r=%0d required 1 1", s_cnt - s0, r_cnt - r0);
    end
  endtask

  task automatic test_nop;
    int s0, r0;
    s0 = s_cnt;
    r0 = r_cnt;
    send(2'b00, 1'b1);
    drain();
    n_cmp++;
    if (s_cnt !== s0 || r_cnt !== r0 || q_exp !== exp_q) begin
      n_err++;
      $display("FAIL nop_quiet s=%0d r=%0d q_exp=%b required 0 0 %b",
               s_cnt - s0, r_cnt - r0, q_exp, exp_q);
    end
  endtask

  task automatic test_retry_err;
    int s0, d0;
    s0 = s_cnt;
    d0 = done_cnt;
    stuck = 1'b1;
    send(2'b10, 1'b0);
    for (int i = 0; i < 60 && !err; i++) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL retry_err err=%b cmd_ready=%b required 1 0", err, cmd_ready);
    end
    n_cmp++;
    if (s_cnt - s0 !== MR + 1) begin
      n_err++;
      $display("FAIL retry_count got %0d required %0d", s_cnt - s0, MR + 1);
    end else begin
      for (int i = 1; i <= MR; i++) begin
        n_cmp++;
        if (s_cyc_arr[s0 + i] - s_cyc_arr[s0 + i - 1] !== D + 2) begin
          n_err++;
          $display("FAIL retry_spacing got %0d required %0d",
                   s_cyc_arr[s0 + i] - s_cyc_arr[s0 + i - 1], D + 2);
        end
      end
    end
    n_cmp++;
    if (done_cnt !== d0) begin
      n_err++;
      $display("FAIL retry_no_done got %0d done pulses required 0", done_cnt - d0);
    end
  endtask

  task automatic test_err_clr;
    int s0;
    s0 = s_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (s_cnt !== s0 || err !== 1'b1 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL err_ignores_cmd s=%0d err=%b ready=%b required 0 1 0",
               s_cnt - s0, err, cmd_ready);
    end
    cmd_valid = 1'b0;
    stuck     = 1'b0;
    err_clr   = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++;
    if (err !== 1'b0 || cmd_ready !== 1'b1 || q_exp !== exp_q) begin
      n_err++;
      $display("FAIL err_clr err=%b ready=%b q_exp=%b required 0 1 %b",
               err, cmd_ready, q_exp, exp_q);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    send(2'b10, 1'b0);
    n_cmp++;
    if (s !== 1'b1) begin
      n_err++;
      $display("FAIL mid_drive s got %b required 1", s);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (s !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async_drop s=%b busy=%b required 0 0", s, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt !== d0 || q_exp !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_after done=%0d q_exp=%b ready=%b required 0 0 1",
               done_cnt - d0, q_exp, cmd_ready);
    end
  endtask

  task automatic test_check_dly3;
    int  k;
    int  dc;
    bit  got;
    @(negedge clk);
    cmd_valid3 = 1'b1;
    cmd_op3    = 2'b10;
    n_cmp++;
    if (cmd_ready3 !== 1'b1) begin
      n_err++;
      $display("FAIL dly3_ready got %b required 1", cmd_ready3);
    end
    @(posedge clk);
    #1;
    k = cyc;
    cmd_valid3 = 1'b0;
    n_cmp++;
    if (s3 !== 1'b1) begin
      n_err++;
      $display("FAIL dly3_s got %b required 1", s3);
    end
    got = 1'b0;
    dc  = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done3) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    n_cmp++;
    if (!got || dc !== k + D3 + 2) begin
      n_err++;
      $display("FAIL dly3_done seen=%b cyc=%0d required cyc %0d", got, dc, k + D3 + 2);
    end
    n_cmp++;
    if (q_exp3 !== 1'b1 || q_fb3 !== 1'b1) begin
      n_err++;
      $display("FAIL dly3_state q_exp=%b q_fb=%b required 1 1", q_exp3, q_fb3);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_valid3 = 1'b0;
    cmd_op3    = 2'b00;
    err_clr    = 1'b0;
    stuck      = 1'b0;
    exp_q      = 1'b0;
    last_acc   = 0;

    test_reset();
    test_set();
    test_back_to_back();
    test_nop();
    test_retry_err();
    test_err_clr();
    test_reset_mid();
    test_check_dly3();

    n_cmp++;
    if (both_seen !== 1'b0) begin
      n_err++;
      $display("FAIL s_r_overlap seen=%b required 0", both_seen);
    end
    n_cmp++;
    if (done_cnt !== rd) begin
      n_err++;
      $display("FAIL stray_done got %0d done pulses required %0d", done_cnt, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
